// File: rtl/sat_skid_pkg.sv
// Shared types and a reference saturation helper for the sat_skid block.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sat_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } sat_skid_state_t;

  localparam int SAT_DIN_W  = 16;
  localparam int SAT_DOUT_W = 8;

  // Saturates a SAT_DIN_W word to SAT_DOUT_W bits; signed_mode selects
  // two's-complement limits instead of unsigned all-ones clipping.
  function automatic logic [SAT_DOUT_W-1:0] sat_fn(input logic [SAT_DIN_W-1:0] din,
                                                   input logic                 signed_mode);
    logic [SAT_DIN_W-SAT_DOUT_W:0] top;
    top = din[SAT_DIN_W-1:SAT_DOUT_W-1];
    if (!signed_mode) begin
      if (din[SAT_DIN_W-1:SAT_DOUT_W] != '0) return '1;
      return din[SAT_DOUT_W-1:0];
    end
    if (!((&top) || !(|top))) begin
      if (din[SAT_DIN_W-1]) return {1'b1, {(SAT_DOUT_W-1){1'b0}}};
      return {1'b0, {(SAT_DOUT_W-1){1'b1}}};
    end
    return din[SAT_DOUT_W-1:0];
  endfunction

endpackage

// File: rtl/sat_skid_if.sv
// Valid/ready word channel used on both sides of sat_skid.
// Latency: n/a (wires only).
// Backpressure: producer holds data/valid until ready is seen on a clock edge.
// Ports: data (W bits), valid, ready. master = producer, slave = consumer.
interface sat_skid_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sat_skid_core.sv
// Combinational saturation of a DIN_W word down to DOUT_W bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: din (DIN_W) in, dout (DOUT_W) out. Requires 1 <= DOUT_W <= DIN_W.
module sat_core #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 8,
  parameter int SIGNED = 0
) (
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] dout
);

  if (DOUT_W == DIN_W) begin : g_pass
    assign dout = din;
  end else if (SIGNED == 0) begin : g_unsigned
    logic ovf;
    assign ovf  = |din[DIN_W-1:DOUT_W];
    assign dout = ovf ? {DOUT_W{1'b1}} : din[DOUT_W-1:0];
  end else begin : g_signed
    // Built by shifting so that DOUT_W == 1 never needs a zero-width replication.
    localparam logic [DOUT_W-1:0] SMIN = DOUT_W'(1) << (DOUT_W - 1);
    localparam logic [DOUT_W-1:0] SMAX = ~SMIN;
    // The dropped bits plus the new sign bit must all agree, otherwise the
    // value does not fit and we clip towards the original sign.
    logic [DIN_W-DOUT_W:0] top;
    logic                  ovf;
    assign top  = din[DIN_W-1:DOUT_W-1];
    assign ovf  = !((&top) || !(|top));
    assign dout = !ovf ? din[DOUT_W-1:0] : (din[DIN_W-1] ? SMIN : SMAX);
  end

endmodule

// File: rtl/sat_skid.sv
// Saturates each accepted word and presents it through a 2-entry skid buffer.
// Latency: 1 cycle (word accepted on edge N is on dout after edge N).
// Backpressure: din.ready is registered and drops only when both entries are
// held; it rises one cycle after the output transfer that frees the skid entry.
// Ports: clk, rst (async active-low), din (slave, DIN_W), dout (master, DOUT_W).
module sat_skid
  import sat_skid_pkg::*;
#(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 8,
  parameter int SIGNED = 0
) (
  input  logic       clk,
  input  logic       rst,
  sat_skid_if.slave  din,
  sat_skid_if.master dout
);

  sat_skid_state_t   state_q, state_d;
  logic [DOUT_W-1:0] main_q, main_d;
  logic [DOUT_W-1:0] skid_q, skid_d;
  logic [DOUT_W-1:0] sat_w;
  logic              vld_q, rdy_q;
  logic              in_xfer, out_xfer;

  sat_core #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .SIGNED (SIGNED)
  ) u_core (
    .din  (din.data),
    .dout (sat_w)
  );

  assign in_xfer  = din.valid & rdy_q;
  assign out_xfer = vld_q & dout.ready;

  // main_q always holds the head word; skid_q only fills when the head is
  // stalled and a new word arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = sat_w;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = sat_w;
        end else if (in_xfer) begin
          skid_d  = sat_w;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are flopped from the next state so they stay pure
  // register outputs rather than decodes of the state vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      vld_q   <= (state_d != EMPTY);
      rdy_q   <= (state_d != FULL);
    end
  end

  assign dout.valid = vld_q;
  assign dout.data  = main_q;
  assign din.ready  = rdy_q;

endmodule

// File: tb/tb_sat_skid.sv
// Self-checking bench for sat_skid: unsigned, signed and pass-through instances.
module tb_sat_skid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  sat_skid_if #(.W(16)) in0 ();
  sat_skid_if #(.W(8))  out0 ();
  sat_skid_if #(.W(16)) in1 ();
  sat_skid_if #(.W(8))  out1 ();
  sat_skid_if #(.W(16)) in2 ();
  sat_skid_if #(.W(16)) out2 ();

  sat_skid #(.DIN_W(16), .DOUT_W(8),  .SIGNED(0)) u0 (.clk(clk), .rst(rst), .din(in0), .dout(out0));
  sat_skid #(.DIN_W(16), .DOUT_W(8),  .SIGNED(1)) u1 (.clk(clk), .rst(rst), .din(in1), .dout(out1));
  sat_skid #(.DIN_W(16), .DOUT_W(16), .SIGNED(1)) u2 (.clk(clk), .rst(rst), .din(in2), .dout(out2));

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  // Arithmetic clamp model, independent of any bit-slicing formulation.
  function automatic logic [15:0] model_sat(input logic [15:0] d, input int w, input bit sgn);
    longint v, hi, lo, mask;
    if (sgn) begin
      v  = longint'($signed(d));
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
    end else begin
      v  = longint'({48'd0, d});
      hi = (longint'(1) << w) - 1;
      lo = 0;
    end
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    mask = (longint'(1) << w) - 1;
    return 16'(v & mask);
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({out0.valid, in0.ready, out0.data} !== {1'b0, 1'b1, 8'h00}) begin
      fails++; $display("FAIL reset_u0 got v=%b r=%b d=%h want v=0 r=1 d=00", out0.valid, in0.ready, out0.data);
    end
    tests++;
    if ({out1.valid, in1.ready, out1.data} !== {1'b0, 1'b1, 8'h00}) begin
      fails++; $display("FAIL reset_u1 got v=%b r=%b d=%h want v=0 r=1 d=00", out1.valid, in1.ready, out1.data);
    end
    tests++;
    if ({out2.valid, in2.ready, out2.data} !== {1'b0, 1'b1, 16'h0000}) begin
      fails++; $display("FAIL reset_u2 got v=%b r=%b d=%h want v=0 r=1 d=0000", out2.valid, in2.ready, out2.data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [15:0] w[3];
    logic [7:0]  e[3];
    logic [15:0] exp;
    w = '{16'h0042, 16'h0100, 16'hFFFF};
    e = '{8'h42, 8'hFF, 8'hFF};
    out0.ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in0.valid = 1'b1;
      in0.data  = w[i];
      tests++;
      if (in0.ready !== 1'b1) begin
        fails++; $display("FAIL uns_ready[%0d] got %b want 1", i, in0.ready);
      end
      q0.push_back({8'h00, e[i]});
      @(negedge clk);
      exp = q0.pop_front();
      tests++;
      if (out0.valid !== 1'b1 || 16'(out0.data) !== exp) begin
        fails++; $display("FAIL uns_out[%0d] got v=%b d=%h want v=1 d=%h", i, out0.valid, out0.data, exp[7:0]);
      end
    end
    in0.valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out0.valid !== 1'b0) begin
      fails++; $display("FAIL uns_drain got v=%b want 0", out0.valid);
    end
  endtask

  task automatic test_signed();
    logic [15:0] w[5];
    logic [7:0]  e[5];
    logic [15:0] exp;
    w = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000};
    e = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80};
    out1.ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in1.valid = 1'b1;
      in1.data  = w[i];
      q1.push_back({8'h00, e[i]});
      @(negedge clk);
      exp = q1.pop_front();
      tests++;
      if (out1.valid !== 1'b1 || 16'(out1.data) !== exp) begin
        fails++; $display("FAIL sgn_out[%0d] got v=%b d=%h want v=1 d=%h", i, out1.valid, out1.data, exp[7:0]);
      end
    end
    in1.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          idx = 0;
    int          got = 0;
    int          acc_at_drop = -1;
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;
    logic [15:0] exp;
    out0.ready = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        tests++;
        if (out0.valid !== 1'b1 || out0.data !== data_prev) begin
          fails++; $display("FAIL bp_stall got v=%b d=%h want v=1 d=%h", out0.valid, out0.data, data_prev);
        end
      end
      if (cyc == 2) begin
        tests++;
        if (out0.valid !== 1'b1 || out0.data !== 8'h01) begin
          fails++; $display("FAIL bp_head got v=%b d=%h want v=1 d=01", out0.valid, out0.data);
        end
      end
      if (cyc == 3) out0.ready = 1'b1;
      in0.valid = (idx < 6);
      in0.data  = 16'(idx + 1);
      if (in0.ready === 1'b0 && acc_at_drop < 0) acc_at_drop = idx;
      if (in0.valid && in0.ready) begin
        q0.push_back(model_sat(16'(idx + 1), 8, 1'b0));
        idx++;
      end
      if (out0.valid && out0.ready) begin
        exp = q0.pop_front();
        got++;
        tests++;
        if (16'(out0.data) !== exp) begin
          fails++; $display("FAIL bp_order[%0d] got %h want %h", got, out0.data, exp[7:0]);
        end
      end
      stall_prev = out0.valid & ~out0.ready;
      data_prev  = out0.data;
    end
    @(negedge clk);
    in0.valid = 1'b0;
    tests++;
    if (acc_at_drop != 2) begin
      fails++; $display("FAIL bp_drop got accepts=%0d want 2", acc_at_drop);
    end
    tests++;
    if (got != 6 || q0.size() != 0) begin
      fails++; $display("FAIL bp_count got delivered=%0d left=%0d want 6 and 0", got, q0.size());
    end
    @(negedge clk);
    tests++;
    if (out0.valid !== 1'b0) begin
      fails++; $display("FAIL bp_dup got v=%b want 0", out0.valid);
    end
  endtask

  task automatic test_random();
    int          idx = 0;
    int          got = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;
    logic [31:0] r;
    logic [15:0] d;
    logic [15:0] exp;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        tests++;
        if (out1.valid !== 1'b1 || out1.data !== data_prev) begin
          fails++; $display("FAIL rnd_stall got v=%b d=%h want v=1 d=%h", out1.valid, out1.data, data_prev);
        end
      end
      r = $urandom;
      d = r[2] ? r[31:16] : {{8{r[15]}}, r[15:8]};
      in1.valid  = (idx < 1000) && r[0];
      in1.data   = d;
      out1.ready = r[1];
      if (in1.valid && in1.ready) begin
        q1.push_back(model_sat(d, 8, 1'b1));
        idx++;
      end
      if (out1.valid && out1.ready) begin
        got++;
        tests++;
        if (q1.size() == 0) begin
          fails++; $display("FAIL rnd_extra got %h want nothing", out1.data);
        end else begin
          exp = q1.pop_front();
          if (16'(out1.data) !== exp) begin
            fails++; $display("FAIL rnd_data[%0d] got %h want %h", got, out1.data, exp[7:0]);
          end
        end
      end
      stall_prev = out1.valid & ~out1.ready;
      data_prev  = out1.data;
    end
    @(negedge clk);
    in1.valid  = 1'b0;
    out1.ready = 1'b1;
    tests++;
    if (got != 1000 || q1.size() != 0) begin
      fails++; $display("FAIL rnd_count got delivered=%0d left=%0d want 1000 and 0", got, q1.size());
    end
  endtask

  task automatic test_reset_mid();
    out0.ready = 1'b0;
    @(negedge clk);
    in0.valid = 1'b1;
    in0.data  = 16'h0011;
    @(negedge clk);
    in0.data  = 16'h0022;
    @(negedge clk);
    in0.valid = 1'b0;
    tests++;
    if (in0.ready !== 1'b0 || out0.valid !== 1'b1) begin
      fails++; $display("FAIL rm_full got r=%b v=%b want r=0 v=1", in0.ready, out0.valid);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (out0.valid !== 1'b0 || in0.ready !== 1'b1 || out0.data !== 8'h00) begin
      fails++; $display("FAIL rm_async got v=%b r=%b d=%h want v=0 r=1 d=00", out0.valid, in0.ready, out0.data);
    end
    q0.delete();
    @(negedge clk);
    rst = 1'b1;
    out0.ready = 1'b1;
    in0.valid  = 1'b1;
    in0.data   = 16'h0033;
    q0.push_back(model_sat(16'h0033, 8, 1'b0));
    @(negedge clk);
    in0.valid = 1'b0;
    tests++;
    if (out0.valid !== 1'b1 || 16'(out0.data) !== q0.pop_front()) begin
      fails++; $display("FAIL rm_next got v=%b d=%h want v=1 d=33", out0.valid, out0.data);
    end
    @(negedge clk);
    tests++;
    if (out0.valid !== 1'b0) begin
      fails++; $display("FAIL rm_discard got v=%b d=%h want v=0", out0.valid, out0.data);
    end
  endtask

  task automatic test_passthru();
    logic [15:0] w[3];
    logic [15:0] exp;
    w = '{16'h8000, 16'h7FFF, 16'h0001};
    out2.ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in2.valid = 1'b1;
      in2.data  = w[i];
      q2.push_back(w[i]);
      @(negedge clk);
      exp = q2.pop_front();
      tests++;
      if (out2.valid !== 1'b1 || out2.data !== exp) begin
        fails++; $display("FAIL pass[%0d] got v=%b d=%h want v=1 d=%h", i, out2.valid, out2.data, exp);
      end
    end
    in2.valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    in0.valid = 1'b0; in0.data = '0; out0.ready = 1'b0;
    in1.valid = 1'b0; in1.data = '0; out1.ready = 1'b0;
    in2.valid = 1'b0; in2.data = '0; out2.ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_passthru();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
